iommu_ip_ctrl: RTL and testbench
================================

Name: iommu_ip_ctrl

Overview:
- Interrupt-pending controller, directly upstream of the IOMMU MSI interrupt generator.
- Sets and holds the ipsr.cip and ipsr.fip bits from command-queue and fault-queue events.
- Applies software W1C clears and coalesces fault-queue record interrupts by count threshold or timeout.
- Drives cip_o/fip_o to the MSI generator and level wired-signalled interrupt (WSI) lines when wired mode is selected.

Parameters:
N_INT_VEC, 16, number of interrupt vectors / WSI output lines
CNT_W, 8, width of the FQ record coalescing counter
TMR_W, 16, width of the coalescing timer

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
cq_ie_i  in  1  cqcsr.cie; gates setting of cip
fq_ie_i  in  1  fqcsr.fie; gates setting of fip and coalescing
cq_err_i  in  1  one-cycle pulse: CQ error (cmd_to, cmd_ill, cqmf)
cq_fence_wi_i  in  1  one-cycle pulse: IOFENCE.C with WSI=1 completed
fq_rec_i  in  1  one-cycle pulse: new fault record written to FQ
fq_err_i  in  1  one-cycle pulse: FQ error (fqof, fqmf)
ipsr_w1c_i  in  2  software W1C strobe; bit0 clears cip, bit1 clears fip
coal_thresh_i  in  CNT_W  FQ records per fip assertion; 0 or 1 = no coalescing
coal_timeout_i  in  TMR_W  max cycles to hold coalesced records; 0 = no timeout
igs_wsi_i  in  1  1 = wired interrupt mode, 0 = MSI mode
civ_i  in  4  CQ interrupt vector index
fiv_i  in  4  FQ interrupt vector index
cip_o  out  1  registered ipsr.cip
fip_o  out  1  registered ipsr.fip
wsi_o  out  N_INT_VEC  level wired interrupt lines

Behaviour:
- Reset: cip_o=0, fip_o=0, wsi_o=0, counter=0, timer=0, FSM=IDLE. Reset mid-accumulation discards the pending count.
- cip:
  - Next value = set | (cip_q & ~ipsr_w1c_i[0]).
  - set = cq_ie_i & (cq_err_i | cq_fence_wi_i).
  - Set and W1C in the same cycle: set wins.
  - Visible one cycle after the pulse is sampled.
- fip: same set/clear rule with ipsr_w1c_i[1].
  - set = fq_ie_i & (fq_err_i | coalesce_fire).
  - fq_err_i bypasses coalescing: 1-cycle latency.
- Deasserting cq_ie_i or fq_ie_i never clears a set bit; it only blocks new sets.
- Coalescing FSM, states IDLE and ACCUM:
  - fq_ie_i=0: FSM is forced to IDLE, counter and timer cleared, fq_rec_i ignored.
  - IDLE + fq_rec_i:
    - If coal_thresh_i<=1, fire this cycle and stay IDLE.
    - Otherwise go to ACCUM with counter=1 and timer=1.
  - ACCUM, evaluated each cycle:
    - cnt_next = counter + fq_rec_i, saturating at all-ones.
    - Fire if cnt_next >= coal_thresh_i.
    - Also fire if coal_timeout_i!=0 and timer >= coal_timeout_i.
    - On fire: go to IDLE, counter=0, timer=0.
    - Otherwise: counter=cnt_next, timer++ (saturating).
  - Resulting timing: with timeout T, fip rises at the T-th clock edge after the edge that sampled the first record, unless the threshold fires first.
  - coal_thresh_i and coal_timeout_i are compared live; a mid-accumulation change takes effect next evaluation.
  - Fire while fip_q is already 1: no visible change, counter still cleared.
  - W1C of fip does not affect counter or timer.
- wsi_o, driven combinationally from flops only (glitch-free):
  - wsi_o[v] = igs_wsi_i & ((cip_q & civ_i==v) | (fip_q & fiv_i==v)).
  - igs_wsi_i=0: wsi_o=0; cip_o/fip_o are still driven for the MSI generator.
  - civ_i==fiv_i: the shared line stays high while either bit is set.
- The MSI generator detects rising edges. Clearing then re-setting produces a new 0->1 transition of at least one cycle low, since W1C and set are mutually exclusive per cycle.

Test Plan:
- cq_ie_i=1, cq_err_i pulse at cycle 5 -> cip_o=1 from cycle 6. ipsr_w1c_i=01 at cycle 10 -> cip_o=0 at cycle 11. With cq_ie_i=0, same pulse -> cip_o stays 0.
- Same-cycle cq_fence_wi_i pulse and ipsr_w1c_i=01 while cip_o=1 -> cip_o remains 1. W1C alone next cycle -> 0.
- fq_ie_i=1, coal_thresh_i=4, coal_timeout_i=0, fq_rec_i pulses at cycles 1, 3, 5, 7 -> fip_o=1 at cycle 8 only; counter back to 0.
- coal_thresh_i=8, coal_timeout_i=10, single fq_rec_i at cycle 0 -> fip_o rises at cycle 10. fq_err_i pulse at cycle 2 instead -> fip_o=1 at cycle 3.
- ACCUM with 2 records, then fq_ie_i=0 for one cycle, then re-enabled -> no fip. Counter restarts from the next record.
- igs_wsi_i=1, civ_i=3, fiv_i=3, cip then fip set, then cip cleared -> wsi_o[3] high until both are cleared, all other lines 0. igs_wsi_i=0 -> wsi_o=0.

Source files
------------

// File: rtl/iommu_ip_ctrl.sv
// ---------------------------------------------------------------------------
// iommu_ip_ctrl
//   Interrupt-pending controller for the IOMMU. Holds ipsr.cip / ipsr.fip,
//   applies software W1C clears, coalesces fault-queue record interrupts by
//   count threshold or timeout, and drives level wired-signalled interrupt
//   lines when wired mode is selected.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cq_ie_i, fq_ie_i     interrupt enables (gate new sets only)
//   cq_err_i             CQ error pulse
//   cq_fence_wi_i        IOFENCE.C with WSI=1 completion pulse
//   fq_rec_i             new FQ record pulse (coalesced)
//   fq_err_i             FQ error pulse (bypasses coalescing)
//   ipsr_w1c_i           W1C strobe: bit0 clears cip, bit1 clears fip
//   coal_thresh_i        records per fip assertion (0/1 = no coalescing)
//   coal_timeout_i       max cycles to hold coalesced records (0 = none)
//   igs_wsi_i            1 = wired interrupts, 0 = MSI
//   civ_i, fiv_i         CQ / FQ interrupt vector indices
//   cip_o, fip_o         registered pending bits to the MSI generator
//   wsi_o                level wired interrupt lines
// ---------------------------------------------------------------------------
module iommu_ip_ctrl #(
  parameter int unsigned N_INT_VEC = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TMR_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cq_ie_i,
  input  logic                 fq_ie_i,
  input  logic                 cq_err_i,
  input  logic                 cq_fence_wi_i,
  input  logic                 fq_rec_i,
  input  logic                 fq_err_i,
  input  logic [1:0]           ipsr_w1c_i,
  input  logic [CNT_W-1:0]     coal_thresh_i,
  input  logic [TMR_W-1:0]     coal_timeout_i,
  input  logic                 igs_wsi_i,
  input  logic [3:0]           civ_i,
  input  logic [3:0]           fiv_i,
  output logic                 cip_o,
  output logic                 fip_o,
  output logic [N_INT_VEC-1:0] wsi_o
);

  typedef enum logic {
    IDLE,
    ACCUM
  } coal_state_e;

  coal_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_inc;
  logic             coalesce_fire;
  logic             cip_set;
  logic             fip_set;
  logic             cip_q;
  logic             fip_q;

  // Saturating increments so a stalled consumer can never wrap the count
  // back below the threshold or the timer back below the timeout.
  always_comb begin
    cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(fq_rec_i);
    tmr_inc  = (tmr_q == '1) ? tmr_q : tmr_q + TMR_W'(1);
  end

  // Fire decision is combinational so that an uncoalesced record (threshold
  // 0 or 1) and a threshold/timeout hit both reach fip with one-cycle
  // latency. Threshold and timeout are compared live.
  always_comb begin
    coalesce_fire = 1'b0;
    if (fq_ie_i) begin
      case (state_q)
        IDLE:    coalesce_fire = fq_rec_i && (coal_thresh_i <= CNT_W'(1));
        ACCUM:   coalesce_fire = (cnt_next >= coal_thresh_i) ||
                                 ((coal_timeout_i != '0) && (tmr_q >= coal_timeout_i));
        default: coalesce_fire = 1'b0;
      endcase
    end
  end

  // Coalescing FSM. Disabling the FQ interrupt abandons any accumulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else if (!fq_ie_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fq_rec_i && !coalesce_fire) begin
            state_q <= ACCUM;
            cnt_q   <= CNT_W'(1);
            tmr_q   <= TMR_W'(1);
          end
        end
        ACCUM: begin
          if (coalesce_fire) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
          end else begin
            cnt_q <= cnt_next;
            tmr_q <= tmr_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          tmr_q   <= '0;
        end
      endcase
    end
  end

  assign cip_set = cq_ie_i & (cq_err_i | cq_fence_wi_i);
  assign fip_set = fq_ie_i & (fq_err_i | coalesce_fire);

  // Set has priority over W1C in the same cycle; enables only gate sets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cip_q <= 1'b0;
      fip_q <= 1'b0;
    end else begin
      cip_q <= cip_set | (cip_q & ~ipsr_w1c_i[0]);
      fip_q <= fip_set | (fip_q & ~ipsr_w1c_i[1]);
    end
  end

  assign cip_o = cip_q;
  assign fip_o = fip_q;

  // Wired lines decode only flop outputs and static vector selects, so they
  // stay glitch-free. A shared vector is the OR of both pending bits.
  always_comb begin
    wsi_o = '0;
    for (int v = 0; v < int'(N_INT_VEC); v++) begin
      wsi_o[v] = igs_wsi_i & ((cip_q & (civ_i == 4'(v))) |
                              (fip_q & (fiv_i == 4'(v))));
    end
  end

endmodule

// File: tb/tb_iommu_ip_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iommu_ip_ctrl
//   Directed testbench for iommu_ip_ctrl. Inputs change 1 ns after the
//   rising edge and outputs are checked at that same point, so every check
//   sees the state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_iommu_ip_ctrl;

  localparam int unsigned N_INT_VEC = 16;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned TMR_W     = 16;

  logic                 clk_i;
  logic                 rst_ni;
  logic                 cq_ie_i;
  logic                 fq_ie_i;
  logic                 cq_err_i;
  logic                 cq_fence_wi_i;
  logic                 fq_rec_i;
  logic                 fq_err_i;
  logic [1:0]           ipsr_w1c_i;
  logic [CNT_W-1:0]     coal_thresh_i;
  logic [TMR_W-1:0]     coal_timeout_i;
  logic                 igs_wsi_i;
  logic [3:0]           civ_i;
  logic [3:0]           fiv_i;
  logic                 cip_o;
  logic                 fip_o;
  logic [N_INT_VEC-1:0] wsi_o;

  int checks;
  int errors;

  iommu_ip_ctrl #(
    .N_INT_VEC (N_INT_VEC),
    .CNT_W     (CNT_W),
    .TMR_W     (TMR_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cq_ie_i        (cq_ie_i),
    .fq_ie_i        (fq_ie_i),
    .cq_err_i       (cq_err_i),
    .cq_fence_wi_i  (cq_fence_wi_i),
    .fq_rec_i       (fq_rec_i),
    .fq_err_i       (fq_err_i),
    .ipsr_w1c_i     (ipsr_w1c_i),
    .coal_thresh_i  (coal_thresh_i),
    .coal_timeout_i (coal_timeout_i),
    .igs_wsi_i      (igs_wsi_i),
    .civ_i          (civ_i),
    .fiv_i          (fiv_i),
    .cip_o          (cip_o),
    .fip_o          (fip_o),
    .wsi_o          (wsi_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drives one cycle of event pulses, takes the clock edge, then drops them.
  task automatic applyStimulus(input logic a_cq_err, input logic a_cq_fence,
                               input logic a_fq_rec, input logic a_fq_err,
                               input logic [1:0] a_w1c);
    cq_err_i      = a_cq_err;
    cq_fence_wi_i = a_cq_fence;
    fq_rec_i      = a_fq_rec;
    fq_err_i      = a_fq_err;
    ipsr_w1c_i    = a_w1c;
    @(posedge clk_i);
    #1;
    cq_err_i      = 1'b0;
    cq_fence_wi_i = 1'b0;
    fq_rec_i      = 1'b0;
    fq_err_i      = 1'b0;
    ipsr_w1c_i    = 2'b00;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic record();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_ni         = 1'b0;
    cq_ie_i        = 1'b0;
    fq_ie_i        = 1'b0;
    cq_err_i       = 1'b0;
    cq_fence_wi_i  = 1'b0;
    fq_rec_i       = 1'b0;
    fq_err_i       = 1'b0;
    ipsr_w1c_i     = 2'b00;
    coal_thresh_i  = '0;
    coal_timeout_i = '0;
    igs_wsi_i      = 1'b0;
    civ_i          = 4'd0;
    fiv_i          = 4'd0;

    #12;
    checkOutput("reset_cip", 32'(cip_o), 32'd0);
    checkOutput("reset_fip", 32'(fip_o), 32'd0);
    checkOutput("reset_wsi", 32'(wsi_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    $display("[TB] cip set / clear");
    cq_ie_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("cip_set_err", 32'(cip_o), 32'd1);
    idle();
    idle();
    checkOutput("cip_hold", 32'(cip_o), 32'd1);
    checkOutput("wsi_msi_mode", 32'(wsi_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    checkOutput("cip_w1c", 32'(cip_o), 32'd0);
    cq_ie_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("cip_blocked", 32'(cip_o), 32'd0);
    cq_ie_i = 1'b1;

    $display("[TB] cip set wins over W1C");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("cip_set_fence", 32'(cip_o), 32'd1);
    cq_ie_i = 1'b0;
    idle();
    checkOutput("cip_ie_off_hold", 32'(cip_o), 32'd1);
    cq_ie_i = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    checkOutput("cip_set_wins", 32'(cip_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    checkOutput("cip_w1c_after", 32'(cip_o), 32'd0);
    checkOutput("fip_untouched", 32'(fip_o), 32'd0);

    $display("[TB] threshold coalescing");
    fq_ie_i       = 1'b1;
    coal_thresh_i = 8'd4;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, (i % 2 == 0), 1'b0, 2'b00);
      if (i == 5) checkOutput("thr4_before", 32'(fip_o), 32'd0);
    end
    checkOutput("thr4_fire", 32'(fip_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("fip_w1c", 32'(fip_o), 32'd0);
    for (int i = 0; i < 3; i++) record();
    checkOutput("thr4_restart_3", 32'(fip_o), 32'd0);
    record();
    checkOutput("thr4_restart_4", 32'(fip_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    coal_thresh_i = 8'd1;
    record();
    checkOutput("thr1_direct", 32'(fip_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("thr1_w1c", 32'(fip_o), 32'd0);
    coal_thresh_i = 8'd0;
    record();
    checkOutput("thr0_direct", 32'(fip_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);

    $display("[TB] timeout coalescing");
    coal_thresh_i  = 8'd8;
    coal_timeout_i = 16'd10;
    record();
    for (int i = 1; i <= 10; i++) begin
      idle();
      if (i == 9)  checkOutput("tmo_edge9", 32'(fip_o), 32'd0);
      if (i == 10) checkOutput("tmo_edge10", 32'(fip_o), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("tmo_w1c", 32'(fip_o), 32'd0);
    record();
    idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    checkOutput("fq_err_bypass", 32'(fip_o), 32'd1);
    fq_ie_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("fip_w1c_ie_off", 32'(fip_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    checkOutput("fip_blocked", 32'(fip_o), 32'd0);
    fq_ie_i = 1'b1;

    $display("[TB] disable mid-accumulation");
    coal_thresh_i  = 8'd3;
    coal_timeout_i = 16'd0;
    record();
    record();
    checkOutput("acc2", 32'(fip_o), 32'd0);
    fq_ie_i = 1'b0;
    idle();
    fq_ie_i = 1'b1;
    record();
    checkOutput("reen_rec1", 32'(fip_o), 32'd0);
    record();
    checkOutput("reen_rec2", 32'(fip_o), 32'd0);
    record();
    checkOutput("reen_rec3", 32'(fip_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);

    $display("[TB] live threshold change");
    coal_thresh_i = 8'd5;
    record();
    record();
    checkOutput("live_before", 32'(fip_o), 32'd0);
    coal_thresh_i = 8'd2;
    idle();
    checkOutput("live_fire", 32'(fip_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("live_w1c", 32'(fip_o), 32'd0);

    $display("[TB] reset mid-accumulation");
    record();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    checkOutput("rst_mid_fip", 32'(fip_o), 32'd0);
    record();
    checkOutput("rst_discard", 32'(fip_o), 32'd0);
    record();
    checkOutput("rst_then_fire", 32'(fip_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);

    $display("[TB] wired interrupts");
    igs_wsi_i = 1'b1;
    civ_i     = 4'd3;
    fiv_i     = 4'd3;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("wsi_cip", 32'(wsi_o), 32'h0008);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    checkOutput("wsi_both", 32'(wsi_o), 32'h0008);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    checkOutput("wsi_cip_clr", 32'(cip_o), 32'd0);
    checkOutput("wsi_shared_hold", 32'(wsi_o), 32'h0008);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    checkOutput("wsi_all_clr", 32'(wsi_o), 32'h0000);
    civ_i = 4'd5;
    fiv_i = 4'd9;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
    checkOutput("wsi_split", 32'(wsi_o), 32'h0220);
    igs_wsi_i = 1'b0;
    #1;
    checkOutput("wsi_msi_off", 32'(wsi_o), 32'h0000);
    checkOutput("cip_msi_kept", 32'(cip_o), 32'd1);
    checkOutput("fip_msi_kept", 32'(fip_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
